uart_rx_os: RTL and testbench
=============================

// Module: uart_rx_os
// PURPOSE
//  Parametrised 8N1-successor UART receiver: 16x oversampled, majority-vote sampling,
//  configurable data bits/parity/stop bits, valid/ready output with error flags.
//  Sits between the pad-level rx line and the byte consumer (CPU I/O port or FIFO).
//  Replaces the fixed-format receiver in the Synthesis/uart subsystem.
// PARAMETERS
//  SOURCE_FREQ  12_000_000  sourceClk frequency, Hz
//  BAUD         115_200     line rate, bits/s
//  ACC_WIDTH    16          NCO accumulator width (tick = carry out)
//  DATA_BITS    8           data bits per frame, legal 5..9
//  PARITY       0           0 none, 1 even, 2 odd
//  STOP_BITS    1           1 or 2
// PORTS
//  sourceClk   in   1          system clock
//  reset       in   1          synchronous, active-low
//  rx_in       in   1          asynchronous serial line, idle high
//  rx_data     out  DATA_BITS  received word, LSB first on line
//  rx_valid    out  1          rx_data/flags valid; held until rx_ready
//  rx_ready    in   1          consumer accepts word when rx_valid & rx_ready
//  parity_err  out  1          parity mismatch on presented word (0 if PARITY=0)
//  frame_err   out  1          a stop bit sampled low on presented word
//  overrun     out  1          1-cycle pulse: completed frame dropped, output still full
//  break_det   out  1          only with UART_RX_BREAK_DETECT_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (reset==0 at posedge): all outputs 0, state IDLE, accumulator 0, tick count 0;
//    aborts any frame in progress, discards held word.
//  - rx_in through 2-flop synchroniser plus one history flop; falling edge = sync 1->0.
//  - Os tick: acc <= acc[ACC_WIDTH-1:0] + INC; tick = acc[ACC_WIDTH];
//    INC = round(16*BAUD*2^ACC_WIDTH/SOURCE_FREQ), computed at elaboration, ACC_WIDTH+1 bits.
//    Accumulator and 4-bit tick counter cleared on start-edge detect.
//  - Sample = majority of synced rx on os-ticks 7,8,9 of each 16-tick bit cell.
//  - FSM: IDLE -> START on falling edge.
//    START: at tick 8 sample; if 1 -> false start, IDLE (no output); else wait to tick 15 -> DATA.
//    DATA: DATA_BITS cells, shift right into register, bit counter counts down to 0;
//          -> PARITY if PARITY!=0 else STOP.
//    PARITY: one cell; err = (^data ^ sample) != (PARITY==2).
//    STOP: STOP_BITS cells; any sample 0 sets frame flag. After final stop sample (tick 9,
//          not end of cell) -> DELIVER, so back-to-back frames at -2% baud are caught.
//    DELIVER (1 cycle): if output empty or accepted this cycle -> load rx_data,
//          parity_err, frame_err, rx_valid<=1; else overrun<=1 for 1 cycle, word dropped,
//          held word/flags unchanged. -> IDLE.
//  - Handshake: rx_valid falls the cycle after rx_valid&rx_ready unless DELIVER reloads
//    in that same cycle (simultaneous accept+deliver -> new word, rx_valid stays 1).
//  - Flags change only together with rx_data; stable while rx_valid=1.
//  - Falling edge while not IDLE is ignored; a line held low after a frame restarts only
//    after a 1->0 transition.
// CONFIGURATION
//  UART_RX_BREAK_DETECT_EN defined: counter of consecutive low bit cells; when a frame has
//   all data bits 0, parity/stop samples 0 (frame_err), break_det=1 instead of delivering the
//   word (rx_valid not raised); break_det stays 1 until synced rx returns high, then 0.
//  Undefined: break_det tied 0; an all-zero framing-error frame is delivered normally.
// TESTING
//  1. Defaults, send 0xA5 8N1 at nominal baud -> rx_data=0xA5, rx_valid=1, errors 0.
//  2. PARITY=1, send 0x03 with parity bit 1 -> rx_data=0x03, parity_err=1.
//  3. Stop bit driven low on 0x3C -> rx_data=0x3C, frame_err=1; next good frame clears it.
//  4. rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun pulses 1 cycle.
//  5. 0.25-bit low glitch on idle line -> no rx_valid; reset low mid-frame -> all outputs 0.
//  6. Baud +/-3%, DATA_BITS=7 STOP_BITS=2, 0x55 back-to-back x8 -> all 8 received correctly.

Source files
------------

// File: rtl/uart_rx_os_if.sv
// Receive-side handshake bundle: word, valid/ready and per-word status flags.
interface uart_rx_os_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;
    logic                 break_det;

    modport master (
        output rx_data, rx_valid, parity_err, frame_err, overrun, break_det,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, parity_err, frame_err, overrun, break_det,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_os.sv
// 16x oversampled UART receiver, majority-vote sampling, valid/ready output with error flags.
// Optional break detection is built when UART_RX_BREAK_DETECT_EN is defined.
module uart_rx_os #(
    parameter int unsigned SOURCE_FREQ = 12_000_000,
    parameter int unsigned BAUD        = 115_200,
    parameter int unsigned ACC_WIDTH   = 16,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY      = 0,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic         sourceClk,
    input  logic         reset,
    input  logic         rx_in,
    uart_rx_os_if.master rx_if
);

    localparam longint unsigned IncL =
        (((64'(16) * 64'(BAUD)) << ACC_WIDTH) + 64'(SOURCE_FREQ / 2)) / 64'(SOURCE_FREQ);
    localparam logic [ACC_WIDTH:0] Inc     = (ACC_WIDTH + 1)'(IncL);
    localparam logic [3:0]         BitsTop = 4'(DATA_BITS - 1);
    localparam logic [3:0]         StopTop = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StDeliver} state_e;

    state_e               state_q, state_d;
    logic                 rx_meta_q, rx_sync_q, rx_hist_q;
    logic [ACC_WIDTH:0]   acc_q, acc_d;
    logic [3:0]           tick_cnt_q, tick_cnt_d;
    logic [1:0]           samp_q, samp_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_err_q, par_err_d;
    logic                 frm_err_q, frm_err_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 valid_q, valid_d;
    logic                 perr_out_q, perr_out_d;
    logic                 ferr_out_q, ferr_out_d;
    logic                 overrun_q, overrun_d;
    logic                 tick, fall, vote;

`ifdef UART_RX_BREAK_DETECT_EN
    localparam logic [3:0] AllLow = 4'(DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS);
    logic [3:0] low_cnt_q, low_cnt_d;
    logic       brk_q, brk_d;
`endif

    assign tick = acc_q[ACC_WIDTH];
    assign fall = rx_hist_q & ~rx_sync_q;
    // Third vote is the live synced value at tick 9.
    assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_sync_q) | (samp_q[1] & rx_sync_q);

    always_comb begin
        state_d    = state_q;
        acc_d      = {1'b0, acc_q[ACC_WIDTH-1:0]} + Inc;
        tick_cnt_d = tick ? tick_cnt_q + 4'd1 : tick_cnt_q;
        samp_d     = samp_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_err_d  = par_err_q;
        frm_err_d  = frm_err_q;
        data_out_d = data_out_q;
        valid_d    = valid_q & ~rx_if.rx_ready;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        overrun_d  = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
        low_cnt_d  = low_cnt_q;
        brk_d      = brk_q & ~rx_sync_q;
        if (tick && tick_cnt_q == 4'd9 &&
            (state_q == StData || state_q == StParity || state_q == StStop)) begin
            low_cnt_d = vote ? 4'd0 : low_cnt_q + 4'd1;
        end
`endif

        if (tick && tick_cnt_q == 4'd7) samp_d[0] = rx_sync_q;
        if (tick && tick_cnt_q == 4'd8) samp_d[1] = rx_sync_q;

        unique case (state_q)
            StIdle: begin
                if (fall) begin
                    state_d    = StStart;
                    acc_d      = '0;
                    tick_cnt_d = '0;
                    par_err_d  = 1'b0;
                    frm_err_d  = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
                    low_cnt_d  = '0;
`endif
                end
            end
            StStart: begin
                if (tick && tick_cnt_q == 4'd8 && rx_sync_q) begin
                    state_d = StIdle;
                end else if (tick && tick_cnt_q == 4'd15) begin
                    state_d   = StData;
                    bit_cnt_d = BitsTop;
                end
            end
            StData: begin
                if (tick && tick_cnt_q == 4'd9) shift_d = {vote, shift_q[DATA_BITS-1:1]};
                if (tick && tick_cnt_q == 4'd15) begin
                    if (bit_cnt_q != 4'd0) begin
                        bit_cnt_d = bit_cnt_q - 4'd1;
                    end else if (PARITY != 0) begin
                        state_d = StParity;
                    end else begin
                        state_d   = StStop;
                        bit_cnt_d = StopTop;
                    end
                end
            end
            StParity: begin
                if (tick && tick_cnt_q == 4'd9) par_err_d = ((^shift_q) ^ vote) != (PARITY == 2);
                if (tick && tick_cnt_q == 4'd15) begin
                    state_d   = StStop;
                    bit_cnt_d = StopTop;
                end
            end
            StStop: begin
                // Hand off at the last stop sample so a fast next start edge is not missed.
                if (tick && tick_cnt_q == 4'd9) begin
                    if (!vote) frm_err_d = 1'b1;
                    if (bit_cnt_q == 4'd0) state_d = StDeliver;
                end
                if (tick && tick_cnt_q == 4'd15) bit_cnt_d = bit_cnt_q - 4'd1;
            end
            StDeliver: begin
                state_d = StIdle;
`ifdef UART_RX_BREAK_DETECT_EN
                if (low_cnt_q == AllLow) begin
                    brk_d = 1'b1;
                end else
`endif
                if (!valid_q || rx_if.rx_ready) begin
                    data_out_d = shift_q;
                    perr_out_d = par_err_q;
                    ferr_out_d = frm_err_q;
                    valid_d    = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sourceClk) begin
        if (!reset) begin
            state_q    <= StIdle;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_hist_q  <= 1'b1;
            acc_q      <= '0;
            tick_cnt_q <= '0;
            samp_q     <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            low_cnt_q  <= '0;
            brk_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rx_meta_q  <= rx_in;
            rx_sync_q  <= rx_meta_q;
            rx_hist_q  <= rx_sync_q;
            acc_q      <= acc_d;
            tick_cnt_q <= tick_cnt_d;
            samp_q     <= samp_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            overrun_q  <= overrun_d;
`ifdef UART_RX_BREAK_DETECT_EN
            low_cnt_q  <= low_cnt_d;
            brk_q      <= brk_d;
`endif
        end
    end

    assign rx_if.rx_data    = data_out_q;
    assign rx_if.rx_valid   = valid_q;
    assign rx_if.parity_err = perr_out_q;
    assign rx_if.frame_err  = ferr_out_q;
    assign rx_if.overrun    = overrun_q;
`ifdef UART_RX_BREAK_DETECT_EN
    assign rx_if.break_det  = brk_q;
`else
    assign rx_if.break_det  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: default 8N1, even parity, and 7-data/2-stop instances.
`timescale 1ns/1ps
module tb_uart_rx_os;

    localparam real BitNs = 1.0e9 / 115200.0;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   ov_cnt = 0;
    int   got2 = 0;
    int   bad2 = 0;

    always #41.667 clk = ~clk;

    uart_rx_os_if #(.DATA_BITS(8)) if0 ();
    uart_rx_os_if #(.DATA_BITS(8)) if1 ();
    uart_rx_os_if #(.DATA_BITS(7)) if2 ();

    uart_rx_os u0 (.sourceClk(clk), .reset(reset), .rx_in(rx0), .rx_if(if0));
    uart_rx_os #(.PARITY(1)) u1 (.sourceClk(clk), .reset(reset), .rx_in(rx1), .rx_if(if1));
    uart_rx_os #(.DATA_BITS(7), .STOP_BITS(2)) u2 (
        .sourceClk(clk), .reset(reset), .rx_in(rx2), .rx_if(if2)
    );

    always @(negedge clk) if (if0.overrun) ov_cnt++;

    always @(negedge clk) begin
        if (if2.rx_valid && if2.rx_ready) begin
            got2++;
            if (if2.rx_data !== 7'h55 || if2.parity_err || if2.frame_err) bad2++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_line(input int ch, input logic v);
        case (ch)
            0: rx0 = v;
            1: rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    // bits[0] is the start bit; sent LSB first, line returns high afterwards.
    task automatic send(input int ch, input logic [15:0] bits, input int n, input real bns);
        for (int i = 0; i < n; i++) begin
            set_line(ch, bits[i]);
            #(bns);
        end
        set_line(ch, 1'b1);
    endtask

    task automatic accept0();
        @(negedge clk) if0.rx_ready = 1'b1;
        @(negedge clk) if0.rx_ready = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int ov_base;

    initial begin
        if0.rx_ready = 1'b0;
        if1.rx_ready = 1'b0;
        if2.rx_ready = 1'b1;
        settle(5);
        check("rst_valid", 32'(if0.rx_valid), 0);
        check("rst_data", 32'(if0.rx_data), 0);
        check("rst_perr", 32'(if0.parity_err), 0);
        check("rst_ferr", 32'(if0.frame_err), 0);
        check("rst_ovr", 32'(if0.overrun), 0);
        reset = 1'b1;
        settle(20);

        send(0, 16'({1'b1, 8'hA5, 1'b0}), 10, BitNs);
        settle(3);
        check("a5_data", 32'(if0.rx_data), 'hA5);
        check("a5_valid", 32'(if0.rx_valid), 1);
        check("a5_perr", 32'(if0.parity_err), 0);
        check("a5_ferr", 32'(if0.frame_err), 0);
        accept0();
        check("a5_accept", 32'(if0.rx_valid), 0);

        send(0, 16'({1'b1, 8'h11, 1'b0}), 10, BitNs);
        settle(3);
        check("x11_data", 32'(if0.rx_data), 'h11);
        check("x11_valid", 32'(if0.rx_valid), 1);
        ov_base = ov_cnt;
        send(0, 16'({1'b1, 8'h22, 1'b0}), 10, BitNs);
        settle(3);
        check("ovr_pulses", 32'(ov_cnt - ov_base), 1);
        check("ovr_data_held", 32'(if0.rx_data), 'h11);
        check("ovr_valid_held", 32'(if0.rx_valid), 1);
        accept0();

        send(0, 16'({1'b0, 8'h3C, 1'b0}), 10, BitNs);
        send(0, 16'h0001, 1, BitNs);
        check("x3c_data", 32'(if0.rx_data), 'h3C);
        check("x3c_ferr", 32'(if0.frame_err), 1);
        check("x3c_perr", 32'(if0.parity_err), 0);
        accept0();
        send(0, 16'({1'b1, 8'h5A, 1'b0}), 10, BitNs);
        settle(3);
        check("x5a_data", 32'(if0.rx_data), 'h5A);
        check("x5a_ferr", 32'(if0.frame_err), 0);
        accept0();

        // All-zero frame with low stop: delivered as an ordinary framing error.
        send(0, 16'h0000, 10, BitNs);
        send(0, 16'h0001, 1, BitNs);
        check("zero_data", 32'(if0.rx_data), 0);
        check("zero_valid", 32'(if0.rx_valid), 1);
        check("zero_ferr", 32'(if0.frame_err), 1);
        check("zero_brk", 32'(if0.break_det), 0);
        accept0();

        send(0, 16'h0000, 1, BitNs * 0.25);
        send(0, 16'h0001, 1, BitNs * 12.0);
        check("glitch_valid", 32'(if0.rx_valid), 0);

        send(0, 16'({1'b1, 8'h77, 1'b0}), 10, BitNs);
        settle(3);
        check("x77_data", 32'(if0.rx_data), 'h77);
        rx0 = 1'b0;
        #(BitNs * 3.0);
        @(negedge clk) reset = 1'b0;
        settle(2);
        check("midrst_valid", 32'(if0.rx_valid), 0);
        check("midrst_data", 32'(if0.rx_data), 0);
        check("midrst_ferr", 32'(if0.frame_err), 0);
        check("midrst_perr", 32'(if0.parity_err), 0);
        check("midrst_ovr", 32'(if0.overrun), 0);
        rx0 = 1'b1;
        settle(5);
        reset = 1'b1;
        #(BitNs * 12.0);
        check("postrst_valid", 32'(if0.rx_valid), 0);
        send(0, 16'({1'b1, 8'hC3, 1'b0}), 10, BitNs);
        settle(3);
        check("xc3_data", 32'(if0.rx_data), 'hC3);

        // Even parity: 0x03 needs parity 0, 0x07 needs parity 1.
        send(1, 16'({1'b1, 1'b1, 8'h03, 1'b0}), 11, BitNs);
        settle(3);
        check("par03_data", 32'(if1.rx_data), 'h03);
        check("par03_perr", 32'(if1.parity_err), 1);
        @(negedge clk) if1.rx_ready = 1'b1;
        @(negedge clk) if1.rx_ready = 1'b0;
        send(1, 16'({1'b1, 1'b1, 8'h07, 1'b0}), 11, BitNs);
        settle(3);
        check("par07_data", 32'(if1.rx_data), 'h07);
        check("par07_perr", 32'(if1.parity_err), 0);

        got2 = 0;
        bad2 = 0;
        for (int i = 0; i < 8; i++) send(2, 16'({2'b11, 7'h55, 1'b0}), 10, BitNs / 1.03);
        #(BitNs * 2.0);
        check("fast_count", 32'(got2), 8);
        check("fast_bad", 32'(bad2), 0);
        got2 = 0;
        bad2 = 0;
        for (int i = 0; i < 8; i++) send(2, 16'({2'b11, 7'h55, 1'b0}), 10, BitNs * 1.03);
        #(BitNs * 2.0);
        check("slow_count", 32'(got2), 8);
        check("slow_bad", 32'(bad2), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #(BitNs * 400.0);
        errors++;
        $display("FAIL timeout: observed running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
